id_ex_pipe_reg: RTL

- ID/EX pipeline register for the 5-stage RISC-V core.
- Captures decoded operands and control from ID. Drives the EX-side fields (rd_EX, memread_EX, regwrite_EX) that the load-use hazard detector compares against.
- Consumes that detector's stall output: inserts a bubble into EX while the front end holds.
- Also absorbs branch/jump flushes from EX and whole-pipe freezes from the memory-wait logic. A flush that arrives during a freeze is remembered until the freeze ends.

---
 rtl/riscvx_pkg.sv | 27 ++
 rtl/pipe_sat_counter.sv | 28 ++
 rtl/id_ex_pipe_reg.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/riscvx_pkg.sv
// Shared definitions for the 5-stage RISC-V core pipeline registers.
package riscvx_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ALUOP_W = 4;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic branch;
    logic jump;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_HOLD,
    ACT_FLUSH,
    ACT_STALL,
    ACT_LOAD
  } pipe_act_e;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module pipe_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall bubbles, flushes and hold-deferred flushes.
// Define ID_EX_PERF_CNT_EN to add bubble/flush/hold performance counters.
module id_ex_pipe_reg #(
  parameter int unsigned XLEN    = riscvx_pkg::XLEN,
  parameter int unsigned ALUOP_W = riscvx_pkg::ALUOP_W
`ifdef ID_EX_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W   = 32
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_ID,
  input  logic [XLEN-1:0]    pc_ID,
  input  logic [4:0]         rs1_ID,
  input  logic [4:0]         rs2_ID,
  input  logic [4:0]         rd_ID,
  input  logic [XLEN-1:0]    rs1_data_ID,
  input  logic [XLEN-1:0]    rs2_data_ID,
  input  logic [XLEN-1:0]    imm_ID,
  input  logic [ALUOP_W-1:0] alu_op_ID,
  input  logic               regwrite_ID,
  input  logic               memread_ID,
  input  logic               memwrite_ID,
  input  logic               branch_ID,
  input  logic               jump_ID,
  input  logic               stall,
  input  logic               flush,
  input  logic               hold,
  output logic               valid_EX,
  output logic [XLEN-1:0]    pc_EX,
  output logic [XLEN-1:0]    rs1_data_EX,
  output logic [XLEN-1:0]    rs2_data_EX,
  output logic [XLEN-1:0]    imm_EX,
  output logic [4:0]         rs1_EX,
  output logic [4:0]         rs2_EX,
  output logic [4:0]         rd_EX,
  output logic [ALUOP_W-1:0] alu_op_EX,
  output logic               regwrite_EX,
  output logic               memread_EX,
  output logic               memwrite_EX,
  output logic               branch_EX,
  output logic               jump_EX,
`ifdef ID_EX_PERF_CNT_EN
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   flush_cnt,
  output logic [CNT_W-1:0]   hold_cnt,
`endif
  output logic               flush_pending
);

  import riscvx_pkg::*;

  pipe_act_e act;

  logic               valid_d, valid_q;
  logic [XLEN-1:0]    pc_d, pc_q;
  logic [XLEN-1:0]    rs1_data_d, rs1_data_q;
  logic [XLEN-1:0]    rs2_data_d, rs2_data_q;
  logic [XLEN-1:0]    imm_d, imm_q;
  logic [4:0]         rs1_d, rs1_q;
  logic [4:0]         rs2_d, rs2_q;
  logic [4:0]         rd_d, rd_q;
  logic [ALUOP_W-1:0] alu_op_d, alu_op_q;
  ctrl_t              ctrl_id, ctrl_d, ctrl_q;
  logic               flush_pending_d, flush_pending_q;

  assign ctrl_id = '{regwrite: regwrite_ID, memread: memread_ID,
                     memwrite: memwrite_ID, branch: branch_ID, jump: jump_ID};

  always_comb begin
    if (rst) begin
      act = ACT_RESET;
    end else if (hold) begin
      act = ACT_HOLD;
    end else if (flush || flush_pending_q) begin
      act = ACT_FLUSH;
    end else if (stall) begin
      act = ACT_STALL;
    end else begin
      act = ACT_LOAD;
    end
  end

  always_comb begin
    valid_d         = valid_q;
    pc_d            = pc_q;
    rs1_data_d      = rs1_data_q;
    rs2_data_d      = rs2_data_q;
    imm_d           = imm_q;
    rs1_d           = rs1_q;
    rs2_d           = rs2_q;
    rd_d            = rd_q;
    alu_op_d        = alu_op_q;
    ctrl_d          = ctrl_q;
    flush_pending_d = flush_pending_q;
    case (act)
      ACT_HOLD: begin
        flush_pending_d = flush_pending_q | flush;
      end
      // Bubbles leave data fields untouched; only valid, control and indices clear.
      ACT_FLUSH, ACT_STALL: begin
        valid_d         = 1'b0;
        ctrl_d          = CTRL_BUBBLE;
        rd_d            = REG_X0;
        rs1_d           = REG_X0;
        rs2_d           = REG_X0;
        flush_pending_d = 1'b0;
      end
      ACT_LOAD: begin
        valid_d    = valid_ID;
        pc_d       = pc_ID;
        rs1_data_d = rs1_data_ID;
        rs2_data_d = rs2_data_ID;
        imm_d      = imm_ID;
        rs1_d      = rs1_ID;
        rs2_d      = rs2_ID;
        alu_op_d   = alu_op_ID;
        ctrl_d     = valid_ID ? ctrl_id : CTRL_BUBBLE;
        rd_d       = valid_ID ? rd_ID : REG_X0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q         <= 1'b0;
      pc_q            <= '0;
      rs1_data_q      <= '0;
      rs2_data_q      <= '0;
      imm_q           <= '0;
      rs1_q           <= '0;
      rs2_q           <= '0;
      rd_q            <= '0;
      alu_op_q        <= '0;
      ctrl_q          <= CTRL_BUBBLE;
      flush_pending_q <= 1'b0;
    end else begin
      valid_q         <= valid_d;
      pc_q            <= pc_d;
      rs1_data_q      <= rs1_data_d;
      rs2_data_q      <= rs2_data_d;
      imm_q           <= imm_d;
      rs1_q           <= rs1_d;
      rs2_q           <= rs2_d;
      rd_q            <= rd_d;
      alu_op_q        <= alu_op_d;
      ctrl_q          <= ctrl_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  assign valid_EX      = valid_q;
  assign pc_EX         = pc_q;
  assign rs1_data_EX   = rs1_data_q;
  assign rs2_data_EX   = rs2_data_q;
  assign imm_EX        = imm_q;
  assign rs1_EX        = rs1_q;
  assign rs2_EX        = rs2_q;
  assign rd_EX         = rd_q;
  assign alu_op_EX     = alu_op_q;
  assign regwrite_EX   = ctrl_q.regwrite;
  assign memread_EX    = ctrl_q.memread;
  assign memwrite_EX   = ctrl_q.memwrite;
  assign branch_EX     = ctrl_q.branch;
  assign jump_EX       = ctrl_q.jump;
  assign flush_pending = flush_pending_q;

`ifdef ID_EX_PERF_CNT_EN
  pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .clr (rst),
    .inc (act == ACT_STALL),
    .cnt (bubble_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .clr (rst),
    .inc (act == ACT_FLUSH),
    .cnt (flush_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_hold_cnt (
    .clk (clk),
    .clr (rst),
    .inc (act == ACT_HOLD),
    .cnt (hold_cnt)
  );
`endif

endmodule
